// File: rtl/avalon_control_ram.sv
// avalon_control_ram: Avalon-MM slave backed by 2**ADDR_WIDTH words of on-chip RAM.
// Writes take effect on the edge they are sampled; reads return data a fixed two
// cycles after the read strobe is sampled, and back-to-back reads are pipelined.
// Optional feature macro: CTRL_BYTEENABLE_EN (per-byte write masking). Without
// it, slave_byteenable is ignored and every write updates the whole word.
module avalon_control_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   slave_address,
    input  logic                    slave_read,
    input  logic                    slave_write,
    output logic [DATA_WIDTH-1:0]   slave_readdata,
    input  logic [DATA_WIDTH-1:0]   slave_writedata,
    input  logic [DATA_WIDTH/8-1:0] slave_byteenable
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Bus semantics: a strobe (slave_read / slave_write) is a single-cycle
    // request accepted unconditionally on the rising edge where it is high and
    // reset is high. There is no waitrequest; read data appears on
    // slave_readdata after the second rising edge following acceptance, and
    // one request per strobe-cycle is accepted (holding slave_read high issues
    // a new read every cycle at whatever address is presented).

    // Storage has no reset: contents survive reset, zero at configuration.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] pipe_q;
    logic                  rd_v1;
    logic                  rd_v2;
    logic                  wr_en;
    logic                  rd_en;

    // Accesses presented while reset is asserted are dropped.
    assign wr_en = slave_write & reset;
    assign rd_en = slave_read & reset;

`ifdef CTRL_BYTEENABLE_EN
    // Write port: only enabled byte lanes are updated.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (slave_byteenable[i]) begin
                    mem[slave_address][8*i +: 8] <= slave_writedata[8*i +: 8];
                end
            end
        end
    end
`else
    // Byte enables have no effect in this build; kept visible to lint as unused.
    logic unused_byteenable;
    assign unused_byteenable = ^slave_byteenable;

    // Write port: whole word is always updated.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[slave_address] <= slave_writedata;
        end
    end
`endif

    // Read port: registered RAM output plus one pipeline stage. Sampling mem on
    // the same edge as a write returns the pre-write word (read-old-data).
    always_ff @(posedge clk) begin
        ram_q  <= mem[slave_address];
        pipe_q <= ram_q;
    end

    // Read-valid pipeline and output register; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_v1          <= 1'b0;
            rd_v2          <= 1'b0;
            slave_readdata <= '0;
        end else begin
            rd_v1 <= rd_en;
            rd_v2 <= rd_v1;
            if (rd_v2) begin
                slave_readdata <= pipe_q;
            end
        end
    end

endmodule

// File: tb/tb_avalon_control_ram.sv
// Testbench for avalon_control_ram: scenario tasks drive the bus, a reference
// word model predicts read data, and a scoreboard compares each returned word.
module tb_avalon_control_ram;

    localparam int DW = 32;
    localparam int AW = 15;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] slave_address = '0;
    logic          slave_read = 1'b0;
    logic          slave_write = 1'b0;
    logic [DW-1:0] slave_readdata;
    logic [DW-1:0] slave_writedata = '0;
    logic [3:0]    slave_byteenable = '0;

    always #5 clk = ~clk;

    avalon_control_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .slave_address    (slave_address),
        .slave_read       (slave_read),
        .slave_write      (slave_write),
        .slave_readdata   (slave_readdata),
        .slave_writedata  (slave_writedata),
        .slave_byteenable (slave_byteenable)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // ---------------- reference model ----------------
    logic [DW-1:0] model [int];

    function automatic logic [DW-1:0] model_get(input logic [AW-1:0] a);
        if (model.exists(int'(a))) return model[int'(a)];
        return '0;
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                        input logic [3:0] be);
        logic [DW-1:0] w;
        w = model_get(a);
`ifdef CTRL_BYTEENABLE_EN
        for (int i = 0; i < 4; i++) begin
            if (be[i]) w[8*i +: 8] = d[8*i +: 8];
        end
`else
        if (be == 4'h0 || be != 4'h0) w = d;
`endif
        model[int'(a)] = w;
    endfunction

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_exp = '0;
    bit p1 = 0, p2 = 0, fire = 0;

    // A read accepted at edge N completes at edge N+2; reset kills in-flight reads.
    always @(posedge clk) begin
        if (!reset) begin
            p1 = 0; p2 = 0; fire = 0;
        end else begin
            fire = p2;
            p2 = p1;
            p1 = slave_read;
        end
    end

    always @(negedge clk) begin
        if (fire) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read got %h expected no read completion", slave_readdata);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                last_exp = e;
                if (slave_readdata !== e) begin
                    errors++;
                    $display("FAIL read_data got %h expected %h", slave_readdata, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] be);
        slave_read       = rd;
        slave_write      = wr;
        slave_address    = a;
        slave_writedata  = d;
        slave_byteenable = be;
        if (rd) exp_q.push_back(model_get(a));
        if (wr) model_write(a, d, be);
        step();
    endtask

    task automatic idle(input int n);
        slave_read  = 0;
        slave_write = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle(0);
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 0;
        idle(2);
        @(negedge clk);
        checks++;
        if (slave_readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_readdata got %h expected %h", slave_readdata, 32'h0);
        end
        #1;
        reset = 1;
        step();
        @(negedge clk);
        checks++;
        if (slave_readdata !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_readdata got %h expected %h", slave_readdata, 32'h0);
        end
        step();
    endtask

    task automatic test_write_read();
        do_op(0, 1, 15'h0, 32'hDEAD_BEEF, 4'hF);
        do_op(1, 0, 15'h0, 32'h0, 4'hF);
        drain();
    endtask

    task automatic test_back_to_back();
        do_op(0, 1, 15'h7FFF, 32'h1234_5678, 4'hF);
        do_op(0, 1, 15'h0001, 32'hCAFE_F00D, 4'hF);
        do_op(1, 0, 15'h7FFF, 32'h0, 4'h0);
        do_op(1, 0, 15'h0001, 32'h0, 4'h0);
        drain();
    endtask

    task automatic test_byteenable();
        do_op(0, 1, 15'h5, 32'hFFFF_FFFF, 4'hF);
        do_op(0, 1, 15'h5, 32'h0000_0000, 4'b0101);
        do_op(1, 0, 15'h5, 32'h0, 4'hF);
        // Zero-enable write: masked build leaves the word alone.
        do_op(0, 1, 15'h6, 32'h1111_2222, 4'hF);
        do_op(0, 1, 15'h6, 32'h9999_8888, 4'h0);
        do_op(1, 0, 15'h6, 32'h0, 4'h0);
        drain();
    endtask

    task automatic test_read_during_write();
        do_op(0, 1, 15'h2, 32'hAAAA_AAAA, 4'hF);
        do_op(1, 1, 15'h2, 32'h5555_5555, 4'hF);
        do_op(1, 0, 15'h2, 32'h0, 4'hF);
        drain();
    endtask

    task automatic test_hold();
        logic [DW-1:0] held;
        held = last_exp;
        idle(4);
        @(negedge clk);
        checks++;
        if (slave_readdata !== held) begin
            errors++;
            $display("FAIL idle_hold got %h expected %h", slave_readdata, held);
        end
        step();
    endtask

    task automatic test_held_read();
        do_op(1, 0, 15'h0000, 32'h0, 4'h0);
        do_op(1, 0, 15'h7FFF, 32'h0, 4'h0);
        do_op(1, 0, 15'h0001, 32'h0, 4'h0);
        drain();
    endtask

    task automatic test_reset_mid_read();
        // Read issued with no expectation: reset must discard it.
        slave_read    = 1;
        slave_address = 15'h0;
        step();
        slave_read = 0;
        reset      = 0;
        step();
        @(negedge clk);
        checks++;
        if (slave_readdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_read_reset got %h expected %h", slave_readdata, 32'h0);
        end
        #1;
        reset = 1;
        idle(3);
        @(negedge clk);
        checks++;
        if (slave_readdata !== 32'h0) begin
            errors++;
            $display("FAIL discarded_read got %h expected %h", slave_readdata, 32'h0);
        end
        step();
        do_op(1, 0, 15'h0, 32'h0, 4'h0);
        drain();
    endtask

    task automatic test_random();
        for (int a = 8; a < 12; a++) do_op(0, 1, AW'(a), $urandom, 4'hF);
        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(8, 11)), $urandom, 4'($urandom_range(0, 15)));
        end
        drain();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_byteenable();
        test_read_during_write();
        test_hold();
        test_held_read();
        test_reset_mid_read();
        test_random();
        test_hold();
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
